// File: rtl/rename_pkg.sv
// Shared types and constants for the 4-wide rename/dispatch stage.
package rename_pkg;

   localparam int NUM_ARCH = 32;
   localparam int NUM_PHYS = 256;
   localparam int LANES    = 4;

   typedef logic [4:0]  arch_t;
   typedef logic [7:0]  phys_t;
   typedef logic [10:0] opcode_t;
   typedef phys_t [NUM_ARCH-1:0] rat_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } rn_state_t;

   // Architectural registers start mapped to themselves, so 32..255 are free.
   localparam logic [NUM_PHYS-1:0] FREE_RESET = {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

   function automatic rat_t rat_identity();
      rat_t r;
      for (int a = 0; a < NUM_ARCH; a++) begin
         r[a] = phys_t'(a);
      end
      return r;
   endfunction

   function automatic logic [8:0] popcount256(input logic [NUM_PHYS-1:0] v);
      logic [8:0] c;
      c = 9'd0;
      for (int i = 0; i < NUM_PHYS; i++) begin
         c = c + 9'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/free_pick4.sv
// Combinational pick of the four lowest set bits of the free bitmap.
module free_pick4
   import rename_pkg::*;
(
   input  logic [NUM_PHYS-1:0] vec_i,
   output phys_t [LANES-1:0]   pick_o,
   output logic [LANES-1:0]    found_o
);

   logic [NUM_PHYS-1:0] rem_s;

   // Each round takes the lowest remaining bit and removes it for the next round.
   always_comb begin
      rem_s   = vec_i;
      pick_o  = '0;
      found_o = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int i = NUM_PHYS-1; i >= 0; i--) begin
            pick_o[k]  = rem_s[i] ? phys_t'(i) : pick_o[k];
            found_o[k] = found_o[k] | rem_s[i];
         end
         rem_s[pick_o[k]] = rem_s[pick_o[k]] & ~found_o[k];
      end
   end

endmodule

// File: rtl/rename_dispatch_chk.sv
// Protocol checks for rename_dispatch: commits must name allocated registers.
module rename_dispatch_chk
   import rename_pkg::*;
(
   input logic                clk_i,
   input logic                rst_ni,
   input logic [LANES-1:0]    commit_valid_i,
   input logic [31:0]         commit_phys_i,
   input logic [NUM_PHYS-1:0] spec_free_i,
   input logic                accept_i,
   input logic [LANES-1:0]    found_i
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      a_commit_allocated: assert property (@(posedge clk_i) disable iff (!rst_ni)
         commit_valid_i[l] |-> !spec_free_i[commit_phys_i[8*l +: 8]]);
   end

   a_pick_complete: assert property (@(posedge clk_i) disable iff (!rst_ni)
      accept_i |-> (&found_i));

endmodule

// File: rtl/rename_dispatch.sv
// 4-wide rename and ROB-insert stage. Optional stall counters: RENAME_PERF_CNT_EN.
module rename_dispatch
   import rename_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  instValid,
   input  logic [19:0] archDst,
   input  logic [43:0] opcode,
   output logic        instReady,
   input  logic        robFull,
   output logic [3:0]  robInserted,
   output logic [19:0] robArchReg,
   output logic [31:0] robPhysReg,
   output logic [43:0] robOpcode,
   input  logic [3:0]  commitValid,
   input  logic [19:0] commitArch,
   input  logic [31:0] commitPhys,
   input  logic        flush,
   output logic [8:0]  freeCount,
   output logic [31:0] stallRobCycles,
   output logic [31:0] stallFreeCycles
);

   rn_state_t           state_q, state_d;
   rat_t                spec_rat_q, spec_rat_d, arch_rat_q, arch_rat_d;
   logic [NUM_PHYS-1:0] spec_free_q, spec_free_d, arch_free_q, arch_free_d;
   logic [8:0]          free_count_q, free_count_d;
   logic [3:0]          rob_ins_q, rob_ins_d;
   logic [19:0]         rob_arch_q, rob_arch_d;
   logic [31:0]         rob_phys_q, rob_phys_d;
   logic [43:0]         rob_op_q, rob_op_d;
   phys_t [LANES-1:0]   pick_s;
   logic [LANES-1:0]    found_s;
   logic                accept_s;
   logic [2:0]          alloc_cnt_s, freed_cnt_s;
   phys_t               new_s, old_s;

   free_pick4 u_pick (
      .vec_i   (spec_free_q),
      .pick_o  (pick_s),
      .found_o (found_s)
   );

   assign instReady = (state_q == RUN) & ~flush & ~robFull & (free_count_q >= 9'd4);
   assign accept_s  = instReady & (instValid != 4'd0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     state_d = flush ? RECOVER : RUN;
         RECOVER: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Allocation first, then commits in lane order; RECOVER starts from the architectural copy.
   always_comb begin
      spec_rat_d  = (state_q == RECOVER) ? arch_rat_q  : spec_rat_q;
      spec_free_d = (state_q == RECOVER) ? arch_free_q : spec_free_q;
      arch_rat_d  = arch_rat_q;
      arch_free_d = arch_free_q;
      rob_ins_d   = 4'd0;
      rob_arch_d  = rob_arch_q;
      rob_phys_d  = rob_phys_q;
      rob_op_d    = rob_op_q;
      alloc_cnt_s = 3'd0;
      freed_cnt_s = 3'd0;
      new_s       = '0;
      old_s       = '0;
      if (accept_s) begin
         rob_ins_d  = instValid;
         rob_arch_d = 20'd0;
         rob_phys_d = 32'd0;
         rob_op_d   = 44'd0;
         for (int l = 0; l < LANES; l++) begin
            if (instValid[l]) begin
               new_s                            = pick_s[alloc_cnt_s[1:0]];
               spec_free_d[new_s]               = 1'b0;
               spec_rat_d[archDst[5*l +: 5]]    = new_s;
               rob_arch_d[5*l +: 5]             = archDst[5*l +: 5];
               rob_phys_d[8*l +: 8]             = new_s;
               rob_op_d[11*l +: 11]             = opcode[11*l +: 11];
               alloc_cnt_s                      = alloc_cnt_s + 3'd1;
            end else begin
               new_s = '0;
            end
         end
      end else begin
         alloc_cnt_s = 3'd0;
      end
      for (int l = 0; l < LANES; l++) begin
         if (commitValid[l]) begin
            old_s                             = arch_rat_d[commitArch[5*l +: 5]];
            spec_free_d[old_s]                = 1'b1;
            arch_free_d[old_s]                = 1'b1;
            arch_free_d[commitPhys[8*l +: 8]] = 1'b0;
            arch_rat_d[commitArch[5*l +: 5]]  = commitPhys[8*l +: 8];
            freed_cnt_s                       = freed_cnt_s + 3'd1;
         end else begin
            old_s = '0;
         end
      end
      if (state_q == RECOVER) begin
         free_count_d = popcount256(spec_free_d);
      end else begin
         free_count_d = free_count_q - {6'd0, alloc_cnt_s} + {6'd0, freed_cnt_s};
      end
   end

   // State, rename tables and ROB-facing output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= RUN;
         spec_rat_q   <= rat_identity();
         arch_rat_q   <= rat_identity();
         spec_free_q  <= FREE_RESET;
         arch_free_q  <= FREE_RESET;
         free_count_q <= 9'd224;
         rob_ins_q    <= 4'd0;
         rob_arch_q   <= 20'd0;
         rob_phys_q   <= 32'd0;
         rob_op_q     <= 44'd0;
      end else begin
         state_q      <= state_d;
         spec_rat_q   <= spec_rat_d;
         arch_rat_q   <= arch_rat_d;
         spec_free_q  <= spec_free_d;
         arch_free_q  <= arch_free_d;
         free_count_q <= free_count_d;
         rob_ins_q    <= rob_ins_d;
         rob_arch_q   <= rob_arch_d;
         rob_phys_q   <= rob_phys_d;
         rob_op_q     <= rob_op_d;
      end
   end

   assign robInserted = rob_ins_q;
   assign robArchReg  = rob_arch_q;
   assign robPhysReg  = rob_phys_q;
   assign robOpcode   = rob_op_q;
   assign freeCount   = free_count_q;

`ifdef RENAME_PERF_CNT_EN
   logic [31:0] stall_rob_q, stall_free_q;
   logic        stall_rob_s, stall_free_s;

   assign stall_rob_s  = (state_q == RUN) & (instValid != 4'd0) & robFull;
   assign stall_free_s = (state_q == RUN) & (instValid != 4'd0) & ~robFull & (free_count_q < 9'd4);

   // Saturating stall counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_rob_q  <= 32'd0;
         stall_free_q <= 32'd0;
      end else begin
         if (stall_rob_s && (stall_rob_q != 32'hFFFF_FFFF)) begin
            stall_rob_q <= stall_rob_q + 32'd1;
         end
         if (stall_free_s && (stall_free_q != 32'hFFFF_FFFF)) begin
            stall_free_q <= stall_free_q + 32'd1;
         end
      end
   end

   assign stallRobCycles  = stall_rob_q;
   assign stallFreeCycles = stall_free_q;
`else
   assign stallRobCycles  = 32'd0;
   assign stallFreeCycles = 32'd0;
`endif

   rename_dispatch_chk u_chk (
      .clk_i          (clk),
      .rst_ni         (reset),
      .commit_valid_i (commitValid),
      .commit_phys_i  (commitPhys),
      .spec_free_i    (spec_free_q),
      .accept_i       (accept_s),
      .found_i        (found_s)
   );

endmodule

// File: doc/rename_dispatch.md
Name: rename_dispatch

Overview:
4-wide register-rename and dispatch stage. It is the writer side of the reorder buffer insert interface. It allocates physical destination registers from a free list and maintains the speculative and architectural RATs. Each accepted group is presented to the ROB one cycle later. Physical registers are returned on commit, and the speculative state is restored from the architectural state on flush.

Parameters:
NUM_ARCH, 32, architectural registers (5-bit index)
NUM_PHYS, 256, physical registers (8-bit index)
LANES, 4, dispatch/commit width; fixed at 4

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
instValid  input  4  per-lane dispatch valid
archDst  input  20  lane i dest arch reg at [5i+4:5i]
opcode  input  44  lane i opcode at [11i+10:11i]
instReady  output  1  group accepted this cycle when high and instValid!=0
robFull  input  1  ROB full flag
robInserted  output  4  ROB insert lane mask (registered)
robArchReg  output  20  per-lane arch reg to ROB
robPhysReg  output  32  per-lane allocated phys reg to ROB, lane i at [8i+7:8i]
robOpcode  output  44  per-lane opcode to ROB
commitValid  input  4  per-lane commit, lanes in program order 0..3
commitArch  input  20  committed arch dest
commitPhys  input  32  committed phys dest
flush  input  1  pipeline flush pulse
freeCount  output  9  current free physical registers
stallRobCycles  output  32  perf counter (see Optional Feature)
stallFreeCycles  output  32  perf counter

Behaviour:
- Reset (async, reset==0):
  - specRAT[a]=archRAT[a]=a.
  - specFree and archFree bitmaps: bits 32..255 = 1, bits 0..31 = 0.
  - freeCount=224; robInserted=0; all rob* data outputs = 0; state=RUN; counters = 0.
- States:
  - RUN -> RECOVER when flush=1. In the flush cycle, instReady=0 and no allocation.
  - RECOVER -> RUN after exactly 1 cycle. instReady=0 in RECOVER.
- instReady = (state==RUN) & ~flush & ~robFull & (freeCount>=4). It is independent of instValid.
- Acceptance (instReady & instValid!=0):
  - The k-th lowest valid lane receives the k-th lowest set bit of specFree. Those bits are cleared.
  - specRAT is updated per lane in ascending lane order, so a repeated archDst in one group leaves the highest lane's mapping.
- Output register:
  - On acceptance, the next cycle shows robInserted=instValid, with arch/phys/opcode per lane. Invalid lanes drive 0.
  - With no acceptance, robInserted=0 next cycle and the data outputs hold.
- Commit, applied per valid lane in order 0..3, in any state:
  - old = archRAT[commitArch].
  - Set specFree[old] and archFree[old]; clear archFree[commitPhys]; archRAT[commitArch] = commitPhys.
  - A repeated arch in one group frees the earlier lane's phys, so it is chained.
- freeCount_next = freeCount - allocated + freed. Freed bits are allocatable from the next cycle.
- RECOVER cycle:
  - specRAT := archRAT; specFree := archFree.
  - Commits arriving in the flush cycle are included in the copy.
  - Commits in the RECOVER cycle are applied on top of the copied state.
  - freeCount := popcount of the result.
- A reset mid-operation restores the reset state immediately. robInserted drops to 0 asynchronously.
- A commit of a phys reg that is not allocated is an error. It is flagged by assertion only.

Optional Feature:
- Macro: RENAME_PERF_CNT_EN.
- Defined:
  - stallRobCycles increments on cycles with state==RUN, instValid!=0 and robFull=1.
  - stallFreeCycles increments on cycles with state==RUN, instValid!=0, robFull=0 and freeCount<4.
  - Both counters saturate at 2^32-1.
- Undefined: both outputs are constant 0 and no counter flops are built.

Decomposition:
- Package rename_pkg contains:
  - constants NUM_ARCH, NUM_PHYS, LANES;
  - typedefs arch_t [4:0], phys_t [7:0], opcode_t [10:0];
  - enum rn_state_t {RUN, RECOVER}.
- Sub-module free_pick4: combinational pick of the 4 lowest set bits of a 256-bit vector. It returns 4 phys_t plus 4 found flags.

Test Plan:
- Reset, then one group with instValid=1111 and archDst=1,2,3,4 -> next cycle robInserted=1111, robPhysReg=32,33,34,35, freeCount=220, specRAT[1..4]=32..35.
- robFull=1 with instValid=1111 -> instReady=0, robInserted=0 next cycle, freeCount unchanged.
- instValid=0101 with archDst lane0=lane2=7 -> lane0 gets phys 32 and lane2 gets 33. Lanes 1 and 3 are 0. specRAT[7]=33.
- Commit lanes 0..1 with (7,32),(7,33) -> phys 7 and 32 return to the free list, archRAT[7]=33, freeCount rises by 2.
- Allocate 56 full groups after reset -> freeCount=0 and instReady=0. Committing one lane raises freeCount to 1, and instReady stays 0.
- Dispatch 2 groups, commit the first group, then pulse flush -> instReady low for 2 cycles. specRAT then equals archRAT, and the second group's 4 regs are free again: freeCount=224-4+4 = 224.
